ras_stack: RTL and testbench

- Return address stack for the fetch stage.
- Consumes the per-bundle RAS control and branch PC produced by the fetch branch decoder.
- Supplies the predicted return target (top of stack) back to that decoder for RET-type predictions.
- Circular, fixed-depth, with pointer checkpoint/restore so execute-stage mispredict recovery can rewind speculative pushes and pops.

---
 rtl/ras_stack_pkg.sv | 15 +
 rtl/ras_stack_if.sv | 39 +++
 rtl/ras_stack_regfile.sv | 31 +++
 rtl/ras_stack.sv | 90 +++++++++
 tb/tb_ras_stack.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ras_stack_pkg.sv
// Shared fetch definitions: RAS control encodings, return-address increment and default depth.
// Used by both the fetch branch decoder and the return address stack.
package ras_stack_pkg;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_POPPUSH = 2'b11
    } ras_ctrl_e;

    localparam int RAS_INC           = 4;
    localparam int RAS_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/ras_stack_if.sv
// Decoder <-> return address stack connection; the decoder is the master side.
// RAS_OCCUPANCY_EN adds the occupancy checkpoint and empty indication.
interface ras_stack_if #(
    parameter int PTR_W = 3,
    parameter int AW    = 64
);
    logic [1:0]       ras_ctrl_i;
    logic [AW-1:0]    ras_data_i;
    logic             ras_we_i;
    logic             stall_i;
    logic             restore_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [AW-1:0]    ras_top_o;
    logic [PTR_W-1:0] ras_ptr_o;
`ifdef RAS_OCCUPANCY_EN
    logic [PTR_W:0]   restore_cnt_i;
    logic [PTR_W:0]   ras_cnt_o;
    logic             ras_empty_o;
`endif

    modport master (
        output ras_ctrl_i, ras_data_i, ras_we_i, stall_i, restore_i, restore_ptr_i,
`ifdef RAS_OCCUPANCY_EN
        output restore_cnt_i,
        input  ras_cnt_o, ras_empty_o,
`endif
        input  ras_top_o, ras_ptr_o
    );

    modport slave (
        input  ras_ctrl_i, ras_data_i, ras_we_i, stall_i, restore_i, restore_ptr_i,
`ifdef RAS_OCCUPANCY_EN
        input  restore_cnt_i,
        output ras_cnt_o, ras_empty_o,
`endif
        output ras_top_o, ras_ptr_o
    );

endinterface

// File: rtl/ras_stack_regfile.sv
// DEPTH x AW entry storage: one synchronous write port, one combinational read port,
// synchronous clear on rst.
module ras_regfile #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int AW    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [AW-1:0]    wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [AW-1:0]    rdata
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ras_stack.sv
// Circular return address stack with pointer checkpoint/restore for mispredict recovery.
// Optional macro RAS_OCCUPANCY_EN adds a saturating occupancy counter and empty flag.
module ras_stack
    import ras_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int AW    = 64
) (
    input  logic      clk,
    input  logic      rst,
    ras_stack_if.slave ras
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] waddr;
    logic [AW-1:0]    ret_addr;
    logic [AW-1:0]    rdata;
    logic             upd;
    logic             we;
    ras_ctrl_e        ctrl;

    assign ctrl     = ras_ctrl_e'(ras.ras_ctrl_i);
    assign upd      = ras.ras_we_i & ~ras.stall_i & ~ras.restore_i;
    assign ptr_inc  = ptr + PTR_W'(1);
    assign ret_addr = ras.ras_data_i + AW'(RAS_INC);

    // Push writes one slot above the top; pop-then-push overwrites the top in place.
    assign we    = upd & ((ctrl == RAS_PUSH) | (ctrl == RAS_POPPUSH));
    assign waddr = (ctrl == RAS_PUSH) ? ptr_inc : ptr;

    ras_regfile #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (ret_addr),
        .raddr (ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ras.restore_i) begin
            ptr <= ras.restore_ptr_i;
        end else if (upd) begin
            case (ctrl)
                RAS_PUSH: ptr <= ptr_inc;
                RAS_POP:  ptr <= ptr - PTR_W'(1);
                default:  ptr <= ptr;
            endcase
        end
    end

    assign ras.ras_ptr_o = ptr;

`ifdef RAS_OCCUPANCY_EN
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0] cnt;

    // Occupancy saturates at both ends so underflow/overflow never wrap it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ras.restore_i) begin
            cnt <= ras.restore_cnt_i;
        end else if (upd) begin
            case (ctrl)
                RAS_PUSH: cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                RAS_POP:  cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
                default:  cnt <= cnt;
            endcase
        end
    end

    assign ras.ras_cnt_o   = cnt;
    assign ras.ras_empty_o = (cnt == '0);
    assign ras.ras_top_o   = ras.ras_empty_o ? '0 : rdata;
`else
    assign ras.ras_top_o = rdata;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: directed test-plan sequences followed by random traffic,
// checked against a circular-array reference model. Honours RAS_OCCUPANCY_EN.
module tb_ras_stack;
    import ras_stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int AW    = 64;

    typedef struct {
        logic [AW-1:0]    top;
        logic [PTR_W-1:0] ptr;
        logic [PTR_W:0]   cnt;
        logic             empty;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    ras_stack_if #(.PTR_W(PTR_W), .AW(AW)) bus ();

    ras_stack #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ras (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          test_count = 0;
    int          fail_count = 0;
    logic [63:0] model_ent [DEPTH];
    int          model_ptr = 0;
    int          model_cnt = 0;

    // Reference model: a circular array indexed with plain modular arithmetic.
    function automatic exp_t model_step(logic r, logic [1:0] ctrl, logic [63:0] data,
                                        logic we, logic stall, logic restore,
                                        int rptr, int rcnt);
        exp_t e;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_ent[i] = 64'd0;
            model_ptr = 0;
            model_cnt = 0;
        end else if (restore) begin
            model_ptr = rptr;
            model_cnt = rcnt;
        end else if (we && !stall) begin
            if (ctrl == 2'b01) begin
                model_ptr = (model_ptr + 1) % DEPTH;
                model_ent[model_ptr] = data + 64'd4;
                if (model_cnt < DEPTH) model_cnt++;
            end else if (ctrl == 2'b10) begin
                model_ptr = (model_ptr + DEPTH - 1) % DEPTH;
                if (model_cnt > 0) model_cnt--;
            end else if (ctrl == 2'b11) begin
                model_ent[model_ptr] = data + 64'd4;
            end
        end
        e.ptr   = PTR_W'(model_ptr);
        e.cnt   = (PTR_W + 1)'(model_cnt);
        e.empty = (model_cnt == 0);
`ifdef RAS_OCCUPANCY_EN
        e.top   = e.empty ? 64'd0 : model_ent[model_ptr];
`else
        e.top   = model_ent[model_ptr];
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic [1:0] ctrl, input logic [63:0] data,
                                 input logic we, input logic stall, input logic restore,
                                 input int rptr, input int rcnt);
        @(negedge clk);
        rst               = r;
        bus.ras_ctrl_i    = ctrl;
        bus.ras_data_i    = data;
        bus.ras_we_i      = we;
        bus.stall_i       = stall;
        bus.restore_i     = restore;
        bus.restore_ptr_i = PTR_W'(rptr);
`ifdef RAS_OCCUPANCY_EN
        bus.restore_cnt_i = (PTR_W + 1)'(rcnt);
`endif
        @(posedge clk);
        exp_q.push_back(model_step(r, ctrl, data, we, stall, restore, rptr, rcnt));
    endtask

    task automatic checkOutput(input exp_t e);
        test_count++;
        if (bus.ras_top_o !== e.top) begin
            fail_count++;
            $display("[TB] FAIL top: got %h expected %h", bus.ras_top_o, e.top);
        end
        test_count++;
        if (bus.ras_ptr_o !== e.ptr) begin
            fail_count++;
            $display("[TB] FAIL ptr: got %0d expected %0d", bus.ras_ptr_o, e.ptr);
        end
`ifdef RAS_OCCUPANCY_EN
        test_count++;
        if (bus.ras_cnt_o !== e.cnt || bus.ras_empty_o !== e.empty) begin
            fail_count++;
            $display("[TB] FAIL occupancy: got cnt %0d empty %b expected cnt %0d empty %b",
                     bus.ras_cnt_o, bus.ras_empty_o, e.cnt, e.empty);
        end
`endif
    endtask

    // Monitor: outputs settle after posedge, so each queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic push(input logic [63:0] pc);
        applyStimulus(1'b0, RAS_PUSH, pc, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop();
        applyStimulus(1'b0, RAS_POP, 64'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, RAS_NONE, 64'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, RAS_NONE, 64'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        logic [1:0]  r_ctrl;
        logic [63:0] r_data;
        rst               = 1'b1;
        bus.ras_ctrl_i    = 2'b00;
        bus.ras_data_i    = '0;
        bus.ras_we_i      = 1'b0;
        bus.stall_i       = 1'b0;
        bus.restore_i     = 1'b0;
        bus.restore_ptr_i = '0;
`ifdef RAS_OCCUPANCY_EN
        bus.restore_cnt_i = '0;
`endif

        // Reset, then idle with ras_we_i low.
        do_reset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, RAS_PUSH, 64'h1234, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef RAS_OCCUPANCY_EN
        pop();
        push(64'h500);
        do_reset();
`endif

        // Push/pop, coroutine and stall.
        push(64'h1000);
        push(64'h2000);
        pop();
        applyStimulus(1'b0, RAS_POPPUSH, 64'h3000, 1'b1, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, RAS_PUSH, 64'h4000, 1'b1, 1'b1, 1'b0, 0, 0);

        // Overflow wrap: nine pushes into eight entries, then eight pops.
        do_reset();
        for (int i = 0; i < 9; i++) push(64'(i * 16));
        for (int i = 0; i < 8; i++) pop();

        // Restore beats a simultaneous push.
        do_reset();
        push(64'h100);
        push(64'h200);
        push(64'h300);
        applyStimulus(1'b0, RAS_PUSH, 64'h9990, 1'b1, 1'b0, 1'b1, 1, 1);
        applyStimulus(1'b1, RAS_NONE, 64'd0, 1'b0, 1'b0, 1'b1, 5, 5);

        // Return address wraps modulo 2^64.
        push(64'hFFFF_FFFF_FFFF_FFFC);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r_ctrl = 2'($urandom_range(0, 3));
            r_data = {$urandom(), $urandom() & 32'hFFFF_FFFC};
            if ($urandom_range(0, 15) == 0) r_data = 64'hFFFF_FFFF_FFFF_FFFC;
            applyStimulus($urandom_range(0, 63) == 0, r_ctrl, r_data,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, DEPTH - 1),
                          $urandom_range(0, DEPTH));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        test_count++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
